// File: rtl/mut_harness_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mut_harness_pkg
// Description : Shared types, defaults and LFSR step for the mutation harness.
// Revision    : 1.0 - initial release
// ============================================================================
package mut_harness_pkg;

    localparam logic [7:0] C_DEF_SEED = 8'hA5;
    localparam logic [7:0] C_DEF_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DRST = 3'd1,
        S_RUN  = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Galois step; the comparator's replay checker uses the same function.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v, input logic [7:0] taps);
        return (v >> 1) ^ (v[0] ? taps : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mut_stim_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : mut_stim_driver_if
// Description : Stimulus bus between the driver and the ref/uut DUT pair.
// Revision    : 1.0 - initial release
// ============================================================================
interface mut_stim_driver_if #(
    parameter int MUT_W = 1
) ();
    logic [7:0]       data;
    logic             valid;
    logic             ready;
    logic             mismatch;
    logic             dut_rst;
    logic [MUT_W-1:0] mutsel;

    modport master (
        output data, valid, mutsel, dut_rst,
        input  ready, mismatch
    );

    modport slave (
        input  data, valid, mutsel, dut_rst,
        output ready, mismatch
    );
endinterface
`default_nettype wire

// File: rtl/mut_lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : mut_lfsr8
// Description : 8-bit Galois LFSR with synchronous seed load and step enable.
// Revision    : 1.0 - initial release
// ============================================================================
module mut_lfsr8
    import mut_harness_pkg::*;
#(
    parameter logic [7:0] SEED = C_DEF_SEED,
    parameter logic [7:0] TAPS = C_DEF_TAPS
) (
    input  wire logic       i_clk,
    input  wire logic       i_reset,
    input  wire logic       i_load,
    input  wire logic       i_advance,
    output logic [7:0]      o_value
);

    logic [7:0] r_value;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_value <= SEED;
        end else if (i_load) begin
            r_value <= SEED;
        end else if (i_advance) begin
            r_value <= lfsr_next(r_value, TAPS);
        end
    end

    assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/mut_stim_driver.sv
`default_nettype none
// ============================================================================
// Module      : mut_stim_driver
// Description : Walks mutants 1..NUM_MUT, resets the DUT pair, streams LFSR
//               beats and counts mutants the comparator flags as killed.
// Revision    : 1.0 - initial release
// ============================================================================
module mut_stim_driver
    import mut_harness_pkg::*;
#(
    parameter int         NUM_MUT = 1,
    parameter int         MUT_W   = 1,
    parameter int         RST_CYC = 2,
    parameter int         RUN_CYC = 16,
    parameter logic [7:0] SEED    = C_DEF_SEED,
    parameter logic [7:0] TAPS    = C_DEF_TAPS
) (
    input  wire logic         i_clk,
    input  wire logic         i_reset,
    input  wire logic         i_start,
    input  wire logic         i_abort,
    mut_stim_driver_if.master stim,
    output logic              o_busy,
    output logic              o_done,
    output logic [MUT_W:0]    o_kill_cnt
);

    localparam int RST_W  = $clog2(RST_CYC + 1);
    localparam int BEAT_W = $clog2(RUN_CYC + 1);

    localparam logic [RST_W-1:0]  c_rst_last  = RST_W'(RST_CYC - 1);
    localparam logic [RST_W-1:0]  c_rst_one   = RST_W'(1);
    localparam logic [BEAT_W-1:0] c_beat_last = BEAT_W'(RUN_CYC - 1);
    localparam logic [BEAT_W-1:0] c_beat_one  = BEAT_W'(1);
    localparam logic [MUT_W-1:0]  c_mut_one   = MUT_W'(1);
    localparam logic [MUT_W-1:0]  c_mut_last  = MUT_W'(NUM_MUT);
    localparam logic [MUT_W:0]    c_kill_one  = (MUT_W + 1)'(1);
    localparam logic [MUT_W:0]    c_kill_max  = (MUT_W + 1)'(NUM_MUT);

    state_t              r_state;
    logic [7:0]          r_data;
    logic                r_valid;
    logic                r_dut_rst;
    logic [MUT_W-1:0]    r_mutsel;
    logic                r_busy;
    logic                r_done;
    logic [MUT_W:0]      r_kill_cnt;
    logic                r_killed;
    logic [RST_W-1:0]    r_rst_cnt;
    logic [BEAT_W-1:0]   r_beat_cnt;

    logic [7:0]          w_lfsr;
    logic                w_load;
    logic                w_accept;

    assign w_load   = (r_state == S_DRST);
    assign w_accept = (r_state == S_RUN) && r_valid && stim.ready;

    mut_lfsr8 #(
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_lfsr (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (w_load),
        .i_advance (w_accept),
        .o_value   (w_lfsr)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_dut_rst  <= 1'b1;
            r_mutsel   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_kill_cnt <= '0;
            r_killed   <= 1'b0;
            r_rst_cnt  <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_abort && (r_state != S_IDLE)) begin
                r_state   <= S_IDLE;
                r_valid   <= 1'b0;
                r_dut_rst <= 1'b1;
                r_mutsel  <= '0;
                r_busy    <= 1'b0;
                r_killed  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_dut_rst <= 1'b1;
                        r_valid   <= 1'b0;
                        if (i_start && !i_abort) begin
                            r_kill_cnt <= '0;
                            r_busy     <= 1'b1;
                            r_rst_cnt  <= '0;
                            if (NUM_MUT == 0) begin
                                r_state <= S_DONE;
                            end else begin
                                r_mutsel <= c_mut_one;
                                r_state  <= S_DRST;
                            end
                        end
                    end
                    S_DRST: begin
                        r_dut_rst <= 1'b1;
                        r_valid   <= 1'b0;
                        if (r_rst_cnt == c_rst_last) begin
                            // LFSR is reloaded during DRST, so the first beat is the seed.
                            r_state    <= S_RUN;
                            r_dut_rst  <= 1'b0;
                            r_valid    <= 1'b1;
                            r_data     <= SEED;
                            r_beat_cnt <= '0;
                            r_killed   <= 1'b0;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + c_rst_one;
                        end
                    end
                    S_RUN: begin
                        // Mismatch wins over the last beat so a late kill is still counted.
                        if (stim.mismatch) begin
                            r_killed  <= 1'b1;
                            r_state   <= S_NEXT;
                            r_valid   <= 1'b0;
                            r_dut_rst <= 1'b1;
                        end else if (w_accept) begin
                            r_data <= lfsr_next(w_lfsr, TAPS);
                            if (r_beat_cnt == c_beat_last) begin
                                r_state   <= S_NEXT;
                                r_valid   <= 1'b0;
                                r_dut_rst <= 1'b1;
                            end else begin
                                r_beat_cnt <= r_beat_cnt + c_beat_one;
                            end
                        end
                    end
                    S_NEXT: begin
                        r_valid   <= 1'b0;
                        r_dut_rst <= 1'b1;
                        r_killed  <= 1'b0;
                        if (r_killed && (r_kill_cnt < c_kill_max)) begin
                            r_kill_cnt <= r_kill_cnt + c_kill_one;
                        end
                        if (r_mutsel == c_mut_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_mutsel  <= r_mutsel + c_mut_one;
                            r_rst_cnt <= '0;
                            r_state   <= S_DRST;
                        end
                    end
                    S_DONE: begin
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_mutsel <= '0;
                        r_state  <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign stim.data    = r_data;
    assign stim.valid   = r_valid;
    assign stim.dut_rst = r_dut_rst;
    assign stim.mutsel  = r_mutsel;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_kill_cnt   = r_kill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mut_stim_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_mut_stim_driver
// Description : Directed self-checking bench for mut_stim_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mut_stim_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0, abort1 = 1'b0;
    logic start3 = 1'b0, abort3 = 1'b0;
    logic start0 = 1'b0, abort0 = 1'b0;
    logic busy1, done1, busy3, done3, busy0, done0;
    logic [1:0] kill1;
    logic [2:0] kill3;
    logic [1:0] kill0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mut_stim_driver_if #(.MUT_W(1)) if1 ();
    mut_stim_driver_if #(.MUT_W(2)) if3 ();
    mut_stim_driver_if #(.MUT_W(1)) if0 ();

    mut_stim_driver #(.NUM_MUT(1), .MUT_W(1), .RST_CYC(2), .RUN_CYC(3)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_start(start1), .i_abort(abort1),
        .stim(if1.master), .o_busy(busy1), .o_done(done1), .o_kill_cnt(kill1)
    );

    mut_stim_driver #(.NUM_MUT(3), .MUT_W(2), .RST_CYC(2), .RUN_CYC(3)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_start(start3), .i_abort(abort3),
        .stim(if3.master), .o_busy(busy3), .o_done(done3), .o_kill_cnt(kill3)
    );

    mut_stim_driver #(.NUM_MUT(0), .MUT_W(1), .RST_CYC(2), .RUN_CYC(3)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_start(start0), .i_abort(abort0),
        .stim(if0.master), .o_busy(busy0), .o_done(done0), .o_kill_cnt(kill0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] snap1();
        return {if1.dut_rst, if1.valid, if1.data, if1.mutsel, busy1, done1, kill1};
    endfunction

    task automatic test_reset();
        logic [14:0] exp_rst;
        exp_rst = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00};
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (snap1() !== exp_rst) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", snap1(), exp_rst);
        end
        checks++;
        if ({if3.dut_rst, if3.valid, busy3, kill3} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_values_m3: got %b expected 100000", {if3.dut_rst, if3.valid, busy3, kill3});
        end
        rst = 1'b0;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 10 && !if1.valid; i++) tick();
        checks++;
        if (if1.valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_reach_run: got valid=%b expected 1", if1.valid);
        end
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (snap1() !== exp_rst) begin
            errors++;
            $display("FAIL reset_mid_run: got %h expected %h", snap1(), exp_rst);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] got[8];
        int n, nd, first_v, bad_rst;
        n = 0; nd = 0; first_v = -1; bad_rst = 0;
        for (int k = 0; k < 8; k++) got[k] = 8'h00;
        if1.ready = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++;
        if ({if1.mutsel, busy1, if1.dut_rst, if1.valid} !== 4'b1110) begin
            errors++;
            $display("FAIL basic_enter_drst: got %b expected 1110", {if1.mutsel, busy1, if1.dut_rst, if1.valid});
        end
        for (int c = 0; c < 20; c++) begin
            if (if1.valid && first_v < 0) first_v = c;
            if (if1.valid && if1.dut_rst) bad_rst++;
            if (if1.valid && if1.ready) begin
                if (n < 8) got[n] = if1.data;
                n++;
            end
            if (done1) nd++;
            tick();
        end
        checks++;
        if (first_v != 2) begin
            errors++;
            $display("FAIL basic_first_valid: got cycle %0d expected 2", first_v);
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL basic_beats: got %0d expected 3", n);
        end
        checks++;
        if ({got[0], got[1], got[2]} !== 24'hA5EA75) begin
            errors++;
            $display("FAIL basic_data: got %h expected a5ea75", {got[0], got[1], got[2]});
        end
        checks++;
        if (nd != 1 || bad_rst != 0) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%0d rst_during_valid=%0d expected 1 and 0", nd, bad_rst);
        end
        checks++;
        if ({kill1, busy1, if1.dut_rst, if1.mutsel} !== 5'b00010) begin
            errors++;
            $display("FAIL basic_end_state: got %b expected 00010", {kill1, busy1, if1.dut_rst, if1.mutsel});
        end
    endtask

    task automatic test_stall();
        logic [7:0] got[8];
        int n, nd, stall, ea_cnt;
        n = 0; nd = 0; stall = 2; ea_cnt = 0;
        for (int k = 0; k < 8; k++) got[k] = 8'h00;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (if1.valid && n == 1 && stall > 0) begin
                if1.ready = 1'b0;
                stall--;
            end else begin
                if1.ready = 1'b1;
            end
            if (if1.valid && if1.data == 8'hEA) ea_cnt++;
            if (if1.valid && if1.ready) begin
                if (n < 8) got[n] = if1.data;
                n++;
            end
            if (done1) nd++;
            tick();
        end
        if1.ready = 1'b1;
        checks++;
        if (ea_cnt != 3) begin
            errors++;
            $display("FAIL stall_hold: got EA for %0d cycles expected 3", ea_cnt);
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL stall_beats: got %0d expected 3", n);
        end
        checks++;
        if ({got[0], got[1], got[2]} !== 24'hA5EA75) begin
            errors++;
            $display("FAIL stall_data: got %h expected a5ea75", {got[0], got[1], got[2]});
        end
        checks++;
        if (nd != 1) begin
            errors++;
            $display("FAIL stall_done: got %0d pulses expected 1", nd);
        end
    endtask

    task automatic test_multi();
        int bpm[4];
        logic [1:0] seq[8];
        logic [1:0] last;
        int nseq, nd;
        for (int k = 0; k < 4; k++) bpm[k] = 0;
        for (int k = 0; k < 8; k++) seq[k] = 2'd0;
        nseq = 0; nd = 0; last = if3.mutsel;
        if3.ready = 1'b1;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (if3.mutsel != last) begin
                if (nseq < 8) seq[nseq] = if3.mutsel;
                nseq++;
                last = if3.mutsel;
            end
            // mismatch is held high whenever the driver is not streaming; it must be ignored then
            if (!if3.valid) if3.mismatch = 1'b1;
            else if (if3.mutsel == 2'd2 && bpm[2] == 0) if3.mismatch = 1'b1;
            else if (if3.mutsel == 2'd3 && bpm[3] == 2) if3.mismatch = 1'b1;
            else if3.mismatch = 1'b0;
            if (if3.valid && if3.ready) bpm[if3.mutsel]++;
            if (done3) nd++;
            tick();
        end
        if3.mismatch = 1'b0;
        checks++;
        if (bpm[1] != 3 || bpm[2] != 1 || bpm[3] != 3) begin
            errors++;
            $display("FAIL multi_beats: got %0d/%0d/%0d expected 3/1/3", bpm[1], bpm[2], bpm[3]);
        end
        checks++;
        if (nseq != 4 || {seq[0], seq[1], seq[2], seq[3]} !== 8'b01_10_11_00) begin
            errors++;
            $display("FAIL multi_mutsel_seq: got n=%0d %b expected n=4 01101100", nseq, {seq[0], seq[1], seq[2], seq[3]});
        end
        checks++;
        if (kill3 !== 3'd2) begin
            errors++;
            $display("FAIL multi_kill_cnt: got %0d expected 2", kill3);
        end
        checks++;
        if (nd != 1 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL multi_done: got done=%0d busy=%b expected 1 and 0", nd, busy3);
        end
    endtask

    task automatic test_abort();
        int n, nd, leak;
        n = 0; nd = 0; leak = 0;
        if1.ready = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            start1 = (if1.valid && n == 1) ? 1'b1 : 1'b0;
            if (if1.valid && if1.ready) n++;
            if (done1) nd++;
            tick();
        end
        start1 = 1'b0;
        checks++;
        if (n != 3 || nd != 1) begin
            errors++;
            $display("FAIL abort_start_ignored: got beats=%0d done=%0d expected 3 and 1", n, nd);
        end
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        checks++;
        if ({busy1, if1.dut_rst, if1.valid, if1.mutsel} !== 4'b0100) begin
            errors++;
            $display("FAIL abort_state: got %b expected 0100", {busy1, if1.dut_rst, if1.valid, if1.mutsel});
        end
        for (int c = 0; c < 15; c++) begin
            if (done1 || if1.valid || busy1) leak++;
            tick();
        end
        checks++;
        if (leak != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d active cycles expected 0", leak);
        end
    endtask

    task automatic test_zero();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        checks++;
        if ({busy0, done0, if0.dut_rst, if0.valid} !== 4'b1010) begin
            errors++;
            $display("FAIL zero_c1: got %b expected 1010", {busy0, done0, if0.dut_rst, if0.valid});
        end
        tick();
        checks++;
        if ({busy0, done0, if0.dut_rst, if0.valid, kill0} !== 6'b011000) begin
            errors++;
            $display("FAIL zero_done: got %b expected 011000", {busy0, done0, if0.dut_rst, if0.valid, kill0});
        end
        tick();
        checks++;
        if ({busy0, done0, if0.dut_rst} !== 3'b001) begin
            errors++;
            $display("FAIL zero_after: got %b expected 001", {busy0, done0, if0.dut_rst});
        end
    endtask

    initial begin
        if1.ready = 1'b1; if1.mismatch = 1'b0;
        if3.ready = 1'b1; if3.mismatch = 1'b0;
        if0.ready = 1'b1; if0.mismatch = 1'b0;
        test_reset();
        test_basic();
        tick();
        test_stall();
        tick();
        test_multi();
        tick();
        test_abort();
        tick();
        test_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
